dec_scan: RTL
=============

Name: dec_scan

Overview:
- Parametrised, registered one-of-2^SEL_W decoder with active-low outputs and a three-input enable gate (one active-high, two active-low).
- Adds an auto-scan mode: an internal prescaler and index counter step the active output round-robin, for display digit select and LED/row strobing.
- Sits between control logic and display/strobe drivers; replaces hand-instantiated combinational decoders.

Parameters:
- SEL_W, 3, select width; output count NOUT = 2^SEL_W.
- DIV_W, 16, width of prescaler and div input.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- g1  input  1  enable, active high.
- g2_n  input  1  enable, active low.
- g3_n  input  1  enable, active low.
- mode  input  1  0 = direct decode of a; 1 = auto-scan.
- a  input  SEL_W  select in direct mode; ignored in scan mode.
- div  input  DIV_W  scan step period minus one, in clk cycles.
- y  output  NOUT  decoded outputs, active low, registered.
- idx  output  SEL_W  index currently driven (registered).
- wrap  output  1  one-cycle pulse when scan index wraps to the start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: y all ones, idx 0, wrap 0, prescaler 0, state OFF.
- Enable: en = g1 & ~g2_n & ~g3_n, sampled each rising edge.
- All outputs are registered. Input changes appear on y/idx after exactly 1 clk edge.
- Active output: when driving index k, y[k] = 0 and all other bits are 1.
- State machine: OFF, DIRECT, SCAN, evaluated every edge.
  - Next state is OFF when en = 0.
  - Next state is DIRECT when en = 1 and mode = 0.
  - Next state is SCAN when en = 1 and mode = 1.
- OFF:
  - y = all ones; wrap = 0.
  - idx and prescaler hold their values, so a scan resumes where it stopped on re-enable.
- DIRECT:
  - y = ~(1 << a); idx = a.
  - Prescaler cleared to 0; wrap = 0.
- SCAN, step rule:
  - Prescaler increments each cycle.
  - A tick occurs when prescaler >= div. On a tick the prescaler is set to 0 and idx advances by 1 modulo NOUT.
  - Using >= means lowering div below the current count forces a tick on the next edge.
- SCAN, output rule:
  - y always reflects the registered idx.
  - div = 0 advances idx every cycle; div = D gives D+1 cycles per index.
- wrap: asserted for one cycle on the edge where idx changes from NOUT-1 to 0 in SCAN. Never asserted in DIRECT or OFF.
- Entering SCAN from DIRECT:
  - The prescaler is already 0 and idx = last a, so scanning starts from that index.
  - The first step occurs after div+1 cycles in SCAN.
- Entering SCAN from OFF: continues with the held prescaler/idx values.
- Leaving SCAN for DIRECT: prescaler cleared; idx = a on the same edge.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously). The first edge after release evaluates normally.

Optional Feature:
- Macro DEC_SCAN_SKIP_EN.
- When defined:
  - Adds input port skip, width NOUT, after div; skip[k] = 1 excludes index k from scanning.
  - On a tick, idx moves to the next index cyclically after the current one with skip = 0.
  - wrap pulses when the new idx <= the old idx, with the new idx differing from the old (the scan passed the end).
  - If exactly one index is unskipped, idx stays on it and wrap does not pulse.
  - If all bits of skip are 1 in SCAN, y = all ones and idx holds.
  - A currently driven index that becomes skipped keeps driving until the next tick.
  - DIRECT mode ignores skip.
- When undefined: no skip port; every index is visited in order.

Test Plan:
- Reset: hold rst_n = 0 with en = 1, mode = 0, a = 5 -> y = 8'hFF, idx = 0, wrap = 0. Release rst_n; one edge later -> y = 8'hDF, idx = 5.
- Direct sweep: en = 1, mode = 0, a = 0..7 on successive cycles -> one cycle later y = FE, FD, FB, F7, EF, DF, BF, 7F respectively.
- Enable gating: a = 2, try (g1, g2_n, g3_n) = (0,0,0), (1,1,0), (1,0,1) -> y = FF for each; (1,0,0) -> y = FB.
- Scan timing: mode = 1, div = 2, starting from idx 6:
  - idx holds 6 for 3 cycles, then 7 for 3 cycles, then 0.
  - wrap is high exactly on the 7->0 edge.
  - y tracks idx: BF, 7F, FE.
- Freeze/resume: while scanning at idx = 3 with prescaler = 1, drop g1 for 5 cycles -> y = FF, idx = 3. Raise g1 -> y = F7, and the step to idx 4 comes 2 cycles later (div = 2).
- Skip (DEC_SCAN_SKIP_EN), div = 0, skip = 8'b0110_1101:
  - Scan visits idx 1, 4, 7, 1, ...; wrap pulses on each 7->1 step.
  - Set skip = 8'hFF -> y = FF, idx holds.

Source files
------------

// File: rtl/dec_scan.sv
// dec_scan: registered active-low one-of-2^SEL_W decoder with enable gating and round-robin auto-scan.
// Define DEC_SCAN_SKIP_EN to add the skip_i mask that excludes indices from scanning.
module dec_scan #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 16,
  localparam int NOUT = 1 << SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             g1_i,
  input  logic             g2_n_i,
  input  logic             g3_n_i,
  input  logic             mode_i,
  input  logic [SEL_W-1:0] a_i,
  input  logic [DIV_W-1:0] div_i,
`ifdef DEC_SCAN_SKIP_EN
  input  logic [NOUT-1:0]  skip_i,
`endif
  output logic [NOUT-1:0]  y_o,
  output logic [SEL_W-1:0] idx_o,
  output logic             wrap_o
);
  typedef enum logic [1:0] {ST_OFF, ST_DIRECT, ST_SCAN} state_t;
  state_t state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d, step;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [NOUT-1:0] y_q, y_d;
  logic wrap_q, wrap_d, tick, blank, wraps;
`ifdef DEC_SCAN_SKIP_EN
  // Descending search leaves the nearest unskipped successor; none found keeps the current index.
  always_comb begin
    step = idx_q;
    for (int k = NOUT - 1; k >= 1; k--)
      if (!skip_i[idx_q + k[SEL_W-1:0]]) step = idx_q + k[SEL_W-1:0];
  end
  assign blank = &skip_i;
  assign wraps = step < idx_q;
`else
  assign step  = idx_q + 1'b1;
  assign blank = 1'b0;
  assign wraps = &idx_q;
`endif
  always_comb begin
    state_d = !(g1_i && !g2_n_i && !g3_n_i) ? ST_OFF : mode_i ? ST_SCAN : ST_DIRECT;
    tick    = presc_q >= div_i;
    idx_d   = idx_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (state_d == ST_DIRECT) begin
      idx_d   = a_i;
      presc_d = '0;
    end else if (state_d == ST_SCAN) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      idx_d   = tick ? step : idx_q;
      wrap_d  = tick && wraps;
    end
    y_d = (state_d == ST_SCAN && blank) ? '1 : ~(NOUT'(1) << idx_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      idx_q   <= '0;
      presc_q <= '0;
      y_q     <= '1;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      y_q     <= y_d;
      wrap_q  <= wrap_d;
    end
  end
  // While disabled the decode register is don't-care; the registered state blanks the outputs.
  assign y_o    = (state_q == ST_OFF) ? '1 : y_q;
  assign idx_o  = idx_q;
  assign wrap_o = wrap_q;
endmodule
